// File: rtl/serial_regshift.sv
// serial_regshift: register-controlled shift operand (LSL/LSR/ASR/ROR by
// Rs[7:0]) computed one bit per cycle, with NZCV shifter flags.
// Only DATA_W = 32 is meaningful: the saturation counts 32/33 assume it.
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. in_ready
// is high only in IDLE and out_valid only in DONE, so the two never overlap.
// Rd/ShifterFlags are stable for as long as out_valid is held.
module serial_regshift #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        shift_control,
    input  logic [DATA_W-1:0] Rm,
    input  logic [DATA_W-1:0] Rs,
    input  logic              carry_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] Rd,
    output logic [3:0]        ShifterFlags,
    output logic              busy,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_LSR = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;

    state_t            state;
    state_t            state_next;

    // Working registers for the operation in flight
    logic [DATA_W-1:0] w;
    logic              c;
    logic [1:0]        op;
    logic [5:0]        cnt;

    // Combinational helpers
    logic [7:0]        amt;
    logic [5:0]        eff;
    logic              c_init;
    logic [DATA_W-1:0] step_w;
    logic              step_c;

    // Rs[31:8] has no effect on the shift amount
    logic              unused_rs;
    assign unused_rs = ^Rs[DATA_W-1:8];

    function automatic logic [3:0] make_flags(input logic [DATA_W-1:0] r, input logic cf);
        make_flags = {r[DATA_W-1], (r == '0), cf, 1'b0};
    endfunction

    // Effective step count and starting carry for a new request
    always_comb begin
        amt    = Rs[7:0];
        eff    = 6'd0;
        c_init = carry_in;
        case (shift_control)
            OP_LSL, OP_LSR: eff = (amt > 8'd33) ? 6'd33 : amt[5:0];
            OP_ASR:         eff = (amt > 8'd32) ? 6'd32 : amt[5:0];
            default: begin
                eff = {1'b0, amt[4:0]};
                // Rotate by a non-zero multiple of 32: value unchanged, C is the top bit
                if (amt != 8'd0 && amt[4:0] == 5'd0) begin
                    c_init = Rm[DATA_W-1];
                end
            end
        endcase
    end

    // One single-bit shift step of the working value
    always_comb begin
        step_w = w;
        step_c = c;
        case (op)
            OP_LSL: begin
                step_c = w[DATA_W-1];
                step_w = {w[DATA_W-2:0], 1'b0};
            end
            OP_LSR: begin
                step_c = w[0];
                step_w = {1'b0, w[DATA_W-1:1]};
            end
            OP_ASR: begin
                step_c = w[0];
                step_w = {w[DATA_W-1], w[DATA_W-1:1]};
            end
            default: begin
                step_c = w[0];
                step_w = {w[0], w[DATA_W-1:1]};
            end
        endcase
    end

    // Next-state logic and state-derived outputs
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_next = (eff == 6'd0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == 6'd1) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign state_dbg = state;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Working registers and result registers; results load only on entry to DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            w            <= '0;
            c            <= 1'b0;
            op           <= 2'b00;
            cnt          <= 6'd0;
            Rd           <= '0;
            ShifterFlags <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        w   <= Rm;
                        c   <= c_init;
                        op  <= shift_control;
                        cnt <= eff;
                        if (eff == 6'd0) begin
                            Rd           <= Rm;
                            ShifterFlags <= make_flags(Rm, c_init);
                        end
                    end
                end
                SHIFT: begin
                    w   <= step_w;
                    c   <= step_c;
                    cnt <= cnt - 6'd1;
                    if (cnt == 6'd1) begin
                        Rd           <= step_w;
                        ShifterFlags <= make_flags(step_w, step_c);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_regshift.sv
// Directed bench for serial_regshift: a table of operations with
// hand-computed results and latencies, plus hand-written sequences for
// output back-pressure and reset during a shift.
module tb_serial_regshift;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  shift_control;
    logic [31:0] Rm;
    logic [31:0] Rs;
    logic        carry_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Rd;
    logic [3:0]  ShifterFlags;
    logic        busy;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    serial_regshift #(.DATA_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .shift_control(shift_control),
        .Rm           (Rm),
        .Rs           (Rs),
        .carry_in     (carry_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .Rd           (Rd),
        .ShifterFlags (ShifterFlags),
        .busy         (busy),
        .state_dbg    (state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] rm;
        logic [31:0] rs;
        logic        cin;
        logic [31:0] exp_rd;
        logic [3:0]  exp_flags;
        int          exp_lat;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one request, then count edges until out_valid (accept edge counts as 1)
    task automatic issue_and_wait(input logic [1:0] op, input logic [31:0] rm,
                                  input logic [31:0] rs, input logic cin, output int lat);
        @(negedge clk);
        shift_control = op;
        Rm            = rm;
        Rs            = rs;
        carry_in      = cin;
        in_valid      = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Accept the presented result with a one-cycle out_ready pulse
    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int seen;
        logic [31:0] exp_rd;

        // {op, Rm, Rs, carry_in, Rd, flags NZCV, latency}
        vecs[0]  = '{2'b00, 32'h8000_0001, 32'd1,      1'b0, 32'h0000_0002, 4'b0010, 2};
        vecs[1]  = '{2'b01, 32'h0000_1234, 32'h100,    1'b1, 32'h0000_1234, 4'b0010, 1};
        vecs[2]  = '{2'b01, 32'h8000_0000, 32'd32,     1'b0, 32'h0000_0000, 4'b0110, 33};
        vecs[3]  = '{2'b01, 32'h8000_0000, 32'd40,     1'b0, 32'h0000_0000, 4'b0100, 34};
        vecs[4]  = '{2'b10, 32'h8000_0000, 32'd4,      1'b0, 32'hF800_0000, 4'b1000, 5};
        vecs[5]  = '{2'b10, 32'h8000_0000, 32'd200,    1'b0, 32'hFFFF_FFFF, 4'b1010, 33};
        vecs[6]  = '{2'b11, 32'h0000_00F1, 32'h24,     1'b0, 32'h1000_000F, 4'b0000, 5};
        vecs[7]  = '{2'b11, 32'h0000_00F1, 32'h20,     1'b1, 32'h0000_00F1, 4'b0000, 1};
        vecs[8]  = '{2'b00, 32'h8000_0001, 32'd32,     1'b0, 32'h0000_0000, 4'b0110, 33};
        vecs[9]  = '{2'b00, 32'h8000_0001, 32'd33,     1'b1, 32'h0000_0000, 4'b0100, 34};
        vecs[10] = '{2'b00, 32'h8000_0000, 32'd0,      1'b0, 32'h8000_0000, 4'b1000, 1};
        vecs[11] = '{2'b10, 32'h7FFF_FFFF, 32'd32,     1'b1, 32'h0000_0000, 4'b0100, 33};
        vecs[12] = '{2'b11, 32'h8000_0001, 32'd1,      1'b0, 32'hC000_0000, 4'b1010, 2};
        vecs[13] = '{2'b01, 32'h0000_00F0, 32'd5,      1'b0, 32'h0000_0007, 4'b0010, 6};
        vecs[14] = '{2'b00, 32'h0000_0001, 32'd31,     1'b1, 32'h8000_0000, 4'b1000, 32};
        vecs[15] = '{2'b11, 32'h1234_5678, 32'hFF,     1'b1, 32'h2468_ACF0, 4'b0000, 32};
        vecs[16] = '{2'b10, 32'h8000_0000, 32'hFF00,   1'b1, 32'h8000_0000, 4'b1010, 1};

        // Reset
        reset         = 1'b1;
        in_valid      = 1'b0;
        out_ready     = 1'b0;
        shift_control = 2'b00;
        Rm            = 32'h0;
        Rs            = 32'h0;
        carry_in      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_rd", Rd, 32'h0);
        check("reset_flags", {28'd0, ShifterFlags}, 32'd0);
        check("reset_state", {30'd0, state_dbg}, 32'd0);

        // Table-driven operations
        for (int i = 0; i < NV; i++) begin
            check($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
            exp_q.push_back(vecs[i].exp_rd);
            issue_and_wait(vecs[i].op, vecs[i].rm, vecs[i].rs, vecs[i].cin, lat);
            exp_rd = exp_q.pop_front();
            check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_rd", i), Rd, exp_rd);
            check($sformatf("v%0d_flags", i), {28'd0, ShifterFlags}, {28'd0, vecs[i].exp_flags});
            release_result();
            check($sformatf("v%0d_idle_after", i), {31'd0, in_ready}, 32'd1);
        end

        // Back-pressure: result held with out_ready low, in_valid pulses ignored
        exp_q.push_back(32'hF800_0000);
        issue_and_wait(2'b10, 32'h8000_0000, 32'd4, 1'b0, lat);
        exp_rd = exp_q.pop_front();
        check("stall_latency", lat, 5);
        for (int i = 0; i < 10; i++) begin
            in_valid      = (i % 2 == 0);
            shift_control = 2'b00;
            Rm            = $urandom_range(1, 32'h7FFF_FFFF);
            Rs            = 32'd0;
            @(posedge clk);
            #1;
            check($sformatf("stall%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("stall%0d_in_ready", i), {31'd0, in_ready}, 32'd0);
            check($sformatf("stall%0d_rd", i), Rd, exp_rd);
            check($sformatf("stall%0d_flags", i), {28'd0, ShifterFlags}, 32'b1000);
        end
        in_valid = 1'b0;
        release_result();
        check("stall_release_out_valid", {31'd0, out_valid}, 32'd0);
        check("stall_release_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("stall_no_extra_busy", {31'd0, busy}, 32'd0);
        check("stall_no_extra_valid", {31'd0, out_valid}, 32'd0);

        // Reset in the middle of a 20-step LSL
        @(negedge clk);
        shift_control = 2'b00;
        Rm            = 32'h0000_0001;
        Rs            = 32'd20;
        carry_in      = 1'b0;
        in_valid      = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("midreset_busy", {31'd0, busy}, 32'd1);
        check("midreset_state_shift", {30'd0, state_dbg}, 32'd1);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        check("midreset_in_ready", {31'd0, in_ready}, 32'd1);
        check("midreset_rd", Rd, 32'h0);
        check("midreset_flags", {28'd0, ShifterFlags}, 32'd0);
        check("midreset_busy_low", {31'd0, busy}, 32'd0);
        seen = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("midreset_no_result", seen, 0);

        // Back-to-back with out_ready held high
        out_ready = 1'b1;
        issue_and_wait(2'b00, 32'h0000_0003, 32'd2, 1'b0, lat);
        check("b2b_latency", lat, 3);
        check("b2b_rd", Rd, 32'h0000_000C);
        check("b2b_flags", {28'd0, ShifterFlags}, 32'b0000);
        @(posedge clk);
        #1;
        check("b2b_back_idle", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
